// File: rtl/sht30_pkg.sv
// Shared constants for the SHT30 measurement-frame path (CRC-8 parameters, frame layout).
package sht30_pkg;

  localparam logic [7:0] SHT30_CRC_POLY    = 8'h31;
  localparam logic [7:0] SHT30_CRC_INIT    = 8'hFF;
  localparam logic [2:0] SHT30_FRAME_BYTES = 3'd6;
  localparam logic [2:0] SHT30_IDX_TCRC    = 3'd2;
  localparam logic [2:0] SHT30_IDX_HCRC    = 3'd5;
  localparam logic [2:0] SHT30_IDX_REINIT  = 3'd3;

endpackage

// File: rtl/sht30_crc8_step.sv
// One-byte SHT30 CRC-8 update (poly 0x31, MSB first), fully combinational.
module sht30_crc8_step
  import sht30_pkg::*;
(
  input  logic [7:0] crc_in,
  input  logic [7:0] byte_in,
  output logic [7:0] crc_out
);

  logic [7:0] c;

  always_comb begin
    c = crc_in ^ byte_in;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ SHT30_CRC_POLY) : (c << 1);
    end
    crc_out = c;
  end

endmodule

// File: rtl/sht30_frame_check.sv
// SHT30 6-byte frame checker: dual CRC-8 check, commit of T/H codes, saturating error count.
// Define SHT30_AVG_EN to publish a 4-sample moving average instead of the raw codes.
module sht30_frame_check
  import sht30_pkg::*;
#(
  parameter int ERR_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_start,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic [15:0]      T_code,
  output logic [15:0]      H_code,
  output logic             code_valid,
  output logic             crc_err,
  output logic [ERR_W-1:0] err_cnt
);

  logic [2:0]       idx_q, idx_d, cur_idx;
  logic [7:0]       crc_q, crc_d, crc_base, crc_step;
  logic             t_ok_q, t_ok_d;
  logic [15:0]      t_raw_q, t_raw_d, h_raw_q, h_raw_d;
  logic [15:0]      t_code_q, t_code_d, h_code_q, h_code_d;
  logic             code_valid_q, code_valid_d, crc_err_q, crc_err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             consume, byte_match, frame_end, frame_good, frame_bad;

  sht30_crc8_step u_crc (
    .crc_in  (crc_base),
    .byte_in (byte_data),
    .crc_out (crc_step)
  );

  // frame_start wins over the stored index, so a coincident byte lands at position 0
  always_comb begin
    cur_idx    = frame_start ? 3'd0 : idx_q;
    consume    = byte_valid && (cur_idx < SHT30_FRAME_BYTES);
    crc_base   = (cur_idx == 3'd0 || cur_idx == SHT30_IDX_REINIT) ? SHT30_CRC_INIT : crc_q;
    byte_match = (byte_data == crc_base);
    frame_end  = consume && (cur_idx == SHT30_IDX_HCRC);
    frame_good = frame_end && t_ok_q && byte_match;
    frame_bad  = frame_end && !(t_ok_q && byte_match);

    idx_d   = idx_q;
    crc_d   = crc_q;
    t_ok_d  = t_ok_q;
    t_raw_d = t_raw_q;
    h_raw_d = h_raw_q;
    if (frame_start) begin
      idx_d = 3'd0;
      crc_d = SHT30_CRC_INIT;
    end
    if (consume) begin
      idx_d = cur_idx + 3'd1;
      crc_d = crc_step;
      case (cur_idx)
        3'd0:           t_raw_d[15:8] = byte_data;
        3'd1:           t_raw_d[7:0]  = byte_data;
        SHT30_IDX_TCRC: t_ok_d        = byte_match;
        3'd3:           h_raw_d[15:8] = byte_data;
        3'd4:           h_raw_d[7:0]  = byte_data;
        default:        ;
      endcase
    end

    crc_err_d = frame_bad;
    err_cnt_d = (frame_bad && err_cnt_q != {ERR_W{1'b1}})
              ? err_cnt_q + {{(ERR_W-1){1'b0}}, 1'b1} : err_cnt_q;
  end

`ifdef SHT30_AVG_EN
  logic [3:0][15:0] hist_t_q, hist_t_d, hist_h_q, hist_h_d;
  logic             first_q, first_d, commit_q, commit_d;
  logic [17:0]      sum_t, sum_h;

  always_comb begin
    hist_t_d = hist_t_q;
    hist_h_d = hist_h_q;
    first_d  = first_q;
    commit_d = frame_good;
    // the first good sample fills the whole window so the average starts at the real value
    if (frame_good) begin
      first_d  = 1'b0;
      hist_t_d = first_q ? {4{t_raw_q}} : {hist_t_q[2:0], t_raw_q};
      hist_h_d = first_q ? {4{h_raw_q}} : {hist_h_q[2:0], h_raw_q};
    end
    sum_t = 18'(hist_t_q[0]) + 18'(hist_t_q[1]) + 18'(hist_t_q[2]) + 18'(hist_t_q[3]);
    sum_h = 18'(hist_h_q[0]) + 18'(hist_h_q[1]) + 18'(hist_h_q[2]) + 18'(hist_h_q[3]);
    code_valid_d = commit_q;
    t_code_d     = commit_q ? 16'(sum_t >> 2) : t_code_q;
    h_code_d     = commit_q ? 16'(sum_h >> 2) : h_code_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hist_t_q <= '0;
      hist_h_q <= '0;
      first_q  <= 1'b1;
      commit_q <= 1'b0;
    end else begin
      hist_t_q <= hist_t_d;
      hist_h_q <= hist_h_d;
      first_q  <= first_d;
      commit_q <= commit_d;
    end
  end
`else
  always_comb begin
    code_valid_d = frame_good;
    t_code_d     = frame_good ? t_raw_q : t_code_q;
    h_code_d     = frame_good ? h_raw_q : h_code_q;
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q        <= SHT30_FRAME_BYTES;
      crc_q        <= SHT30_CRC_INIT;
      t_ok_q       <= 1'b0;
      t_raw_q      <= '0;
      h_raw_q      <= '0;
      t_code_q     <= '0;
      h_code_q     <= '0;
      code_valid_q <= 1'b0;
      crc_err_q    <= 1'b0;
      err_cnt_q    <= '0;
    end else begin
      idx_q        <= idx_d;
      crc_q        <= crc_d;
      t_ok_q       <= t_ok_d;
      t_raw_q      <= t_raw_d;
      h_raw_q      <= h_raw_d;
      t_code_q     <= t_code_d;
      h_code_q     <= h_code_d;
      code_valid_q <= code_valid_d;
      crc_err_q    <= crc_err_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign T_code     = t_code_q;
  assign H_code     = h_code_q;
  assign code_valid = code_valid_q;
  assign crc_err    = crc_err_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_sht30_frame_check.sv
// Self-checking bench for sht30_frame_check: directed sequences, a frame table and random frames vs a model.
module tb_sht30_frame_check;

`ifdef SHT30_AVG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        frame_start = 1'b0;
  logic        byte_valid = 1'b0;
  logic [7:0]  byte_data = 8'h00;
  logic [15:0] T_code, H_code;
  logic        code_valid, crc_err;
  logic [7:0]  err_cnt;

  sht30_frame_check #(.ERR_W(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .frame_start (frame_start),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .T_code      (T_code),
    .H_code      (H_code),
    .code_valid  (code_valid),
    .crc_err     (crc_err),
    .err_cnt     (err_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cv_cnt = 0;
  int ce_cnt = 0;

  always @(negedge clk) begin
    if (code_valid === 1'b1) cv_cnt++;
    if (crc_err === 1'b1) ce_cnt++;
  end

  initial begin
    #3_000_000;
    $display("FAIL timeout actual=no_finish required=finish");
    $fatal(1, "timeout");
  end

  // reference model: list of accepted samples, averaged over the last four
  int unsigned ht[4], hh[4];
  bit          m_first;
  logic [15:0] m_t, m_h;
  int          m_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] crc8(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] c;
    logic [7:0] d[2];
    d[0] = a; d[1] = b;
    c = 8'hFF;
    for (int k = 0; k < 2; k++) begin
      c = c ^ d[k];
      for (int j = 0; j < 8; j++) c = c[7] ? ((c << 1) ^ 8'h31) : (c << 1);
    end
    return c;
  endfunction

  function automatic bit frame_ok(input logic [47:0] f);
    return (crc8(f[47:40], f[39:32]) == f[31:24]) && (crc8(f[23:16], f[15:8]) == f[7:0]);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin ht[k] = 0; hh[k] = 0; end
    m_first = 1'b1; m_t = 16'h0; m_h = 16'h0; m_err = 0;
  endtask

  task automatic model_commit(input logic [15:0] t, input logic [15:0] h);
`ifdef SHT30_AVG_EN
    if (m_first) begin
      for (int k = 0; k < 4; k++) begin ht[k] = t; hh[k] = h; end
      m_first = 1'b0;
    end else begin
      for (int k = 3; k > 0; k--) begin ht[k] = ht[k-1]; hh[k] = hh[k-1]; end
      ht[0] = t; hh[0] = h;
    end
    m_t = 16'((ht[0] + ht[1] + ht[2] + ht[3]) / 4);
    m_h = 16'((hh[0] + hh[1] + hh[2] + hh[3]) / 4);
`else
    m_t = t; m_h = h;
`endif
  endtask

  task automatic idle(input int n);
    frame_start = 1'b0; byte_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit fs);
    frame_start = fs; byte_valid = 1'b1; byte_data = b;
    @(posedge clk); #1;
    frame_start = 1'b0; byte_valid = 1'b0;
  endtask

  task automatic pulse_start();
    frame_start = 1'b1;
    @(posedge clk); #1;
    frame_start = 1'b0;
  endtask

  task automatic run_frame(input logic [47:0] f, input bit collide, input bit chase,
                           input int gapmax, input int extra, input string name);
    int cv0, ce0;
    bit ok;
    ok = frame_ok(f);
    cv0 = cv_cnt; ce0 = ce_cnt;
    if (!collide) pulse_start();
    for (int i = 0; i < 6; i++) begin
      if (i > 0 && gapmax > 0) idle($urandom_range(gapmax, 0));
      send_byte(f[47-8*i -: 8], collide && i == 0);
    end
    if (chase) pulse_start();
    for (int i = 0; i < extra; i++) send_byte(8'($urandom), 1'b0);
    idle(4);
    if (ok) model_commit(f[47:32], f[23:8]);
    else if (m_err < 255) m_err++;
    chk({name, " code_valid_pulses"}, cv_cnt - cv0, {31'd0, ok});
    chk({name, " crc_err_pulses"}, ce_cnt - ce0, {31'd0, !ok});
    chk({name, " T_code"}, T_code, m_t);
    chk({name, " H_code"}, H_code, m_h);
    chk({name, " err_cnt"}, err_cnt, m_err);
  endtask

  typedef struct {
    logic [47:0] f;
    bit          collide;
    bit          exp_ok;
  } vec_t;

  initial begin
    vec_t vecs[8];
    int   cv0, ce0;
    logic [47:0] f;
    logic [15:0] t, h;

    vecs[0] = '{48'hBEEF92_BEEF92, 1'b0, 1'b1};
    vecs[1] = '{48'hBEEF93_BEEF92, 1'b0, 1'b0};
    vecs[2] = '{48'hBEEF92_BEEF93, 1'b1, 1'b0};
    vecs[3] = '{48'h000081_000081, 1'b1, 1'b1};
    vecs[4] = '{48'h000081_BEEF92, 1'b0, 1'b1};
    vecs[5] = '{48'hBEEF92_000081, 1'b1, 1'b1};
    vecs[6] = '{48'h000181_000081, 1'b0, 1'b0};
    vecs[7] = '{48'hBEEF92_BEEE92, 1'b0, 1'b0};

    model_reset();
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(1);
    chk("reset T_code", T_code, 16'h0);
    chk("reset H_code", H_code, 16'h0);
    chk("reset code_valid", code_valid, 1'b0);
    chk("reset crc_err", crc_err, 1'b0);
    chk("reset err_cnt", err_cnt, 8'h0);

    // after reset the checker waits for frame_start; stray bytes do nothing
    cv0 = cv_cnt; ce0 = ce_cnt;
    for (int i = 0; i < 6; i++) send_byte(8'hBE, 1'b0);
    idle(4);
    chk("stray bytes code_valid_pulses", cv_cnt - cv0, 0);
    chk("stray bytes crc_err_pulses", ce_cnt - ce0, 0);

    // good frame with exact latency
    f = 48'hBEEF92_BEEF92;
    cv0 = cv_cnt;
    pulse_start();
    for (int i = 0; i < 6; i++) send_byte(f[47-8*i -: 8], 1'b0);
    for (int k = 1; k <= 3; k++) begin
      chk($sformatf("good latency code_valid N+%0d", k), code_valid, (k == LAT));
      chk($sformatf("good latency crc_err N+%0d", k), crc_err, 1'b0);
      idle(1);
    end
    model_commit(16'hBEEF, 16'hBEEF);
    chk("good T_code", T_code, 16'hBEEF);
    chk("good H_code", H_code, 16'hBEEF);
    chk("good err_cnt", err_cnt, 8'h0);
    chk("good single pulse", cv_cnt - cv0, 1);

    // bad T CRC: error pulse on N+1, outputs hold
    f = 48'hBEEF93_BEEF92;
    cv0 = cv_cnt;
    pulse_start();
    for (int i = 0; i < 6; i++) send_byte(f[47-8*i -: 8], 1'b0);
    for (int k = 1; k <= 3; k++) begin
      chk($sformatf("badT crc_err N+%0d", k), crc_err, (k == 1));
      chk($sformatf("badT code_valid N+%0d", k), code_valid, 1'b0);
      idle(1);
    end
    m_err = 1;
    chk("badT err_cnt", err_cnt, 8'd1);
    chk("badT T_code hold", T_code, 16'hBEEF);
    chk("badT H_code hold", H_code, 16'hBEEF);
    chk("badT no code_valid", cv_cnt - cv0, 0);

    run_frame(48'h000081_000081, 1'b0, 1'b0, 0, 0, "second good");
`ifdef SHT30_AVG_EN
    chk("avg T_code", T_code, 16'h8F33);
    chk("avg H_code", H_code, 16'h8F33);
`else
    chk("raw T_code", T_code, 16'h0000);
    chk("raw H_code", H_code, 16'h0000);
`endif

    // abort: partial BE EF discarded silently
    ce0 = ce_cnt;
    pulse_start();
    send_byte(8'hBE, 1'b0);
    send_byte(8'hEF, 1'b0);
    run_frame(48'h000081_000081, 1'b0, 1'b0, 0, 0, "abort");
    chk("abort no crc_err", ce_cnt - ce0, 0);

    // frame_start with byte 0, then overrun bytes; also frame_start right after the last byte
    run_frame(48'h000081_000081, 1'b1, 1'b0, 0, 3, "collide overrun");
    run_frame(48'hBEEF92_BEEF92, 1'b0, 1'b1, 0, 0, "chase start");

    for (int i = 0; i < 8; i++) begin
      cv0 = cv_cnt;
      run_frame(vecs[i].f, vecs[i].collide, 1'b0, 1, 0, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d table ok", i), cv_cnt - cv0, {31'd0, vecs[i].exp_ok});
    end

    for (int i = 0; i < 40; i++) begin
      t = 16'($urandom); h = 16'($urandom);
      f = {t, crc8(t[15:8], t[7:0]), h, crc8(h[15:8], h[7:0])};
      if ($urandom_range(3, 0) == 0) f[8*$urandom_range(5, 0) +: 8] ^= 8'($urandom_range(255, 1));
      if ($urandom_range(4, 0) == 0) begin
        pulse_start();
        for (int j = 0; j < $urandom_range(5, 1); j++) send_byte(8'($urandom), 1'b0);
      end
      run_frame(f, $urandom_range(2, 0) == 0, $urandom_range(3, 0) == 0, 2,
                $urandom_range(2, 0), $sformatf("rand%0d", i));
    end

    // saturation
    for (int i = 0; i < 260; i++) run_frame(48'hBEEF93_BEEF92, 1'b1, 1'b0, 0, 0, "sat");
    chk("saturated err_cnt", err_cnt, 8'd255);

    // reset mid-frame
    pulse_start();
    send_byte(8'hBE, 1'b0);
    send_byte(8'hEF, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    chk("midreset T_code", T_code, 16'h0);
    chk("midreset H_code", H_code, 16'h0);
    chk("midreset err_cnt", err_cnt, 8'h0);
    chk("midreset code_valid", code_valid, 1'b0);
    chk("midreset crc_err", crc_err, 1'b0);
    cv0 = cv_cnt; ce0 = ce_cnt;
    for (int i = 0; i < 4; i++) send_byte(8'h92, 1'b0);
    idle(4);
    chk("midreset leftovers ignored", (cv_cnt - cv0) + (ce_cnt - ce0), 0);
    run_frame(48'hBEEF92_BEEF92, 1'b0, 1'b0, 0, 0, "post reset good");
    chk("post reset T_code", T_code, 16'hBEEF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
